// File: rtl/spi_seq_pkg.sv
// Shared types and field layout for the SPI command sequencer.
// SPI_SEQ_GAP_EN adds the GAP state (inter-command idle time).
package spi_seq_pkg;

  localparam int unsigned CMD_W      = 24;
  localparam int unsigned CMD_ADDR_W = 16;
  localparam int unsigned CMD_DATA_W = 8;

  // Field bit positions inside a command word.
  localparam int unsigned CMD_ADDR_MSB = 23;
  localparam int unsigned CMD_ADDR_LSB = 8;
  localparam int unsigned CMD_DATA_MSB = 7;
  localparam int unsigned CMD_DATA_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRstAssert,
    StRstWait,
    StFetch,
    StLatch,
    StPresent,
    StDone
`ifdef SPI_SEQ_GAP_EN
    ,
    StGap
`endif
  } seq_state_e;

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable down-counter shared by the timed sequencer states.
// Holds at zero once it gets there; zero flag is decoded from the count.
module spi_seq_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] count;

  // Load on state entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// RF-chip power-up sequencer: pulses xreset, waits for the chip, then streams
// NUM_CMDS command words from an external synchronous ROM over valid/ready.
// Define SPI_SEQ_GAP_EN to insert GAP_CYCLES idle cycles between commands.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned NUM_CMDS     = 368,
  parameter int unsigned RESET_CYCLES = 2000,
  parameter int unsigned READY_WAIT   = 200,
  parameter int unsigned GAP_CYCLES   = 8,
  localparam int unsigned IdxW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             xreset,
  output logic [IdxW-1:0]  rom_addr,
  input  logic [CMD_W-1:0] rom_data,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_data,
  input  logic             cmd_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MaxRw  = (RESET_CYCLES > READY_WAIT) ? RESET_CYCLES : READY_WAIT;
  localparam int unsigned MaxCyc = (MaxRw > GAP_CYCLES) ? MaxRw : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] RstLoad  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLoad = CntW'(READY_WAIT - 1);
`ifdef SPI_SEQ_GAP_EN
  localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`endif
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_CMDS - 1);

  seq_state_e      state;
  logic [IdxW-1:0] idx;
  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_zero;
  logic            last_cmd;
  logic            start_ok;

  assign last_cmd = (idx == LastIdx);
  assign start_ok = start && ((state == StIdle) || (state == StDone));
  assign rom_addr = idx;

  // Timer reload on entry to each timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (start_ok) begin
      tmr_load = 1'b1;
      tmr_val  = RstLoad;
    end else if ((state == StRstAssert) && tmr_zero) begin
      tmr_load = 1'b1;
      tmr_val  = WaitLoad;
`ifdef SPI_SEQ_GAP_EN
    end else if ((state == StPresent) && cmd_ready && !last_cmd && (GAP_CYCLES > 0)) begin
      tmr_load = 1'b1;
      tmr_val  = GapLoad;
`endif
    end
  end

  spi_seq_timer #(
    .Width (CntW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      xreset    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state  <= StRstAssert;
            xreset <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        StRstAssert: begin
          if (tmr_zero) begin
            state  <= StRstWait;
            xreset <= 1'b1;
          end
        end
        StRstWait: begin
          if (tmr_zero) begin
            state <= StFetch;
          end
        end
        // ROM samples rom_addr at the end of this cycle.
        StFetch: begin
          state <= StLatch;
        end
        StLatch: begin
          cmd_data  <= rom_data;
          cmd_valid <= 1'b1;
          state     <= StPresent;
        end
        StPresent: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (last_cmd) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
`ifdef SPI_SEQ_GAP_EN
              state <= (GAP_CYCLES > 0) ? StGap : StFetch;
`else
              state <= StFetch;
`endif
            end
          end
        end
`ifdef SPI_SEQ_GAP_EN
        StGap: begin
          if (tmr_zero) begin
            state <= StFetch;
          end
        end
`endif
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer: ROM model, expected-word queue
// popped on every handshake, plus latency, stall, reset and restart checks.
module tb_spi_cmd_sequencer;

  localparam int unsigned NumCmds = 4;
  localparam int unsigned RstCyc  = 10;
  localparam int unsigned WaitCyc = 5;
  localparam int unsigned GapCyc  = 8;
`ifdef SPI_SEQ_GAP_EN
  localparam int Spacing = 3 + GapCyc;
`else
  localparam int Spacing = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        xreset;
  logic [1:0]  rom_addr;
  logic [23:0] rom_data;
  logic        cmd_valid;
  logic [23:0] cmd_data;
  logic        cmd_ready;
  logic        busy;
  logic        done;

  logic [23:0] rom_mem [NumCmds];
  logic [23:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  spi_cmd_sequencer #(
    .NUM_CMDS     (NumCmds),
    .RESET_CYCLES (RstCyc),
    .READY_WAIT   (WaitCyc),
    .GAP_CYCLES   (GapCyc)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .xreset    (xreset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: one-cycle read latency.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_xreset"}, 32'(xreset), 0);
    check_eq({tag, "_valid"}, 32'(cmd_valid), 0);
    check_eq({tag, "_data"}, 32'(cmd_data), 0);
    check_eq({tag, "_addr"}, 32'(rom_addr), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
  endtask

  // Runs one sequence from a negedge. stall_idx: command held with ready low
  // for 20 cycles; kill_idx: command during which reset is pulsed;
  // poke_wait: extra start pulse during RST_WAIT.
  task automatic run_seq(input int stall_idx, input int kill_idx, input bit poke_wait);
    int lo;
    int hi;
    int n;
    int last_hs;
    int budget;
    logic [23:0] exp_w;
    for (int i = 0; i < NumCmds; i++) exp_q.push_back(rom_mem[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lo = 0;
    while (xreset == 1'b0 && lo < 100) begin
      lo++;
      @(negedge clk);
    end
    check_eq("xreset_low_cycles", lo, RstCyc);
    hi = 0;
    while (!cmd_valid && hi < 100) begin
      start = (poke_wait && hi == 2);
      hi++;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("first_valid_latency", hi, WaitCyc + 2);
    n = 0;
    last_hs = -1;
    budget = 0;
    while (n < NumCmds && budget < 500) begin
      budget++;
      if (cmd_valid) begin
        if (n == kill_idx) begin
          #2 reset = 1'b1;
          #1 check_reset_vals("async_reset");
          @(negedge clk);
          reset = 1'b0;
          exp_q.delete();
          return;
        end
        if (n == stall_idx) begin
          cmd_ready = 1'b0;
          repeat (20) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(cmd_valid), 1);
            check_eq("stall_data", 32'(cmd_data), 32'(rom_mem[n]));
            check_eq("stall_addr", 32'(rom_addr), n);
          end
          cmd_ready = 1'b1;
        end
        check_eq("hs_addr", 32'(rom_addr), n);
        check_eq("hs_busy", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          check_eq("hs_unexpected", 32'(cmd_data), 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("hs_data", 32'(cmd_data), 32'(exp_w));
        end
        if (last_hs >= 0 && n != stall_idx) check_eq("hs_spacing", cyc + 1 - last_hs, Spacing);
        last_hs = cyc + 1;
        n++;
      end
      @(negedge clk);
    end
    check_eq("cmd_count", n, NumCmds);
    check_eq("end_done", 32'(done), 1);
    check_eq("end_busy", 32'(busy), 0);
    check_eq("end_valid", 32'(cmd_valid), 0);
    check_eq("end_xreset", 32'(xreset), 1);
  endtask

  initial begin
    rom_mem[0] = 24'h000101;
    rom_mem[1] = 24'h000202;
    rom_mem[2] = 24'h000303;
    rom_mem[3] = 24'h000404;
    reset = 1'b1;
    start = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");
    // Plain run, then restart from DONE with a stall on command 2.
    run_seq(-1, -1, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("done_hold", 32'(done), 1);
    run_seq(1, -1, 1'b0);
    // Reset while command 3 pending, then full replay from IDLE.
    run_seq(-1, 2, 1'b0);
    @(negedge clk);
    check_reset_vals("post_reset");
    run_seq(-1, -1, 1'b0);
    // Start pulse during RST_WAIT must be ignored.
    run_seq(-1, -1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Upstream feeder for the RF-chip SPI master shifter. After `start`, it runs the chip power-up sequence: it drives `xreset` low for `RESET_CYCLES`, then high, then waits `READY_WAIT` cycles. It then streams `NUM_CMDS` 24-bit command words (16-bit register address, 8-bit data) from a synchronous command ROM to the shifter over a valid/ready handshake.

## Interface
Parameters:
- `NUM_CMDS`, 368: number of command words in the ROM; must be ≥1.
- `RESET_CYCLES`, 2000: cycles `xreset` is held low; must be ≥1.
- `READY_WAIT`, 200: cycles waited after `xreset` rises; must be ≥1.
- `GAP_CYCLES`, 8: idle cycles between commands; used only with `SPI_SEQ_GAP_EN`.

Ports:
- `clk` input 1: system clock. One clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: begin sequence. Sampled only in IDLE or DONE; ignored otherwise.
- `xreset` output 1: RF chip reset, active-low.
- `rom_addr` output `$clog2(NUM_CMDS)`: registered ROM read address.
- `rom_data` input 24: ROM word. Valid one cycle after `rom_addr` is sampled.
- `cmd_valid` output 1: `cmd_data` holds a command.
- `cmd_data` output 24: bits [23:8] are the address, bits [7:0] are the data.
- `cmd_ready` input 1: shifter accepts the command.
- `busy` output 1: high in every state except IDLE and DONE.
- `done` output 1: high in DONE.

## Operation
- States and transitions:
  - IDLE → RST_ASSERT when `start` is sampled.
  - RST_ASSERT → RST_WAIT after `RESET_CYCLES` cycles.
  - RST_WAIT → FETCH after `READY_WAIT` cycles.
  - FETCH → LATCH after 1 cycle.
  - LATCH → PRESENT after 1 cycle.
  - PRESENT → FETCH, GAP, or DONE on handshake.
  - GAP → FETCH after `GAP_CYCLES` cycles.
  - DONE → RST_ASSERT when `start` is sampled.
- `xreset` values: 0 in IDLE and RST_ASSERT; 1 in all other states.
- One shared down-counter times the RST_ASSERT, RST_WAIT and GAP states. It is loaded with N-1 on state entry and the state exits when the count reaches 0, so each state lasts exactly N cycles.
- A command index register holds the current command. It clears on entry to RST_ASSERT and increments on each handshake. `rom_addr` equals the index.
- FETCH: the ROM samples `rom_addr`.
- LATCH: `cmd_data <= rom_data` at the end of the cycle.
- PRESENT:
  - `cmd_valid` = 1 and `cmd_data` is held stable until the handshake.
  - The handshake is `cmd_valid && cmd_ready` at a rising edge.
  - On handshake, if index == `NUM_CMDS`-1, go to DONE; otherwise increment the index and go to FETCH (or GAP when enabled).
- `cmd_ready` is ignored outside PRESENT.
- `cmd_valid` never deasserts without a handshake, except on `reset`.
- Arithmetic:
  - Counter width is `$clog2(max(RESET_CYCLES, READY_WAIT, GAP_CYCLES)+1)`.
  - The index never wraps; DONE is entered instead.
- A `start` arriving while busy has no effect and is not queued.

## Timing
- Reset values:
  - State IDLE.
  - `xreset`=0, `cmd_valid`=0, `cmd_data`=0, `rom_addr`=0.
  - `busy`=0, `done`=0.
  - Counter 0, index 0.
- Reset mid-operation: outputs return to their reset values immediately (asynchronously). A pending command is dropped without a handshake.
- `start` sampled at edge t:
  - `xreset` low from t+1 through t+`RESET_CYCLES`.
  - `xreset` rises at edge t+`RESET_CYCLES`.
  - The first `cmd_valid` asserts `READY_WAIT`+2 cycles after `xreset` rises.
- With `cmd_ready` tied high, consecutive commands are accepted every 3 cycles (every 3+`GAP_CYCLES` with the gap enabled).
- `done` rises at the edge of the final handshake. `busy` falls at the same edge.

## Configuration
- `SPI_SEQ_GAP_EN` defined: after every non-final handshake the block spends `GAP_CYCLES` in GAP before FETCH. `GAP_CYCLES`=0 skips GAP.
- `SPI_SEQ_GAP_EN` undefined: the GAP state and its logic are absent; PRESENT goes directly to FETCH.

## Structure
- Package `spi_seq_pkg` holds:
  - the state enum;
  - `CMD_W`=24, `CMD_ADDR_W`=16, `CMD_DATA_W`=8;
  - the field bit positions.
- Sub-module `spi_seq_timer`: loadable down-counter with a `zero` flag, shared by the timed states.
- The ROM is external. `NUM_CMDS` must match the ROM depth.

## Test plan
Bench parameters: `NUM_CMDS`=4, `RESET_CYCLES`=10, `READY_WAIT`=5, with a ROM model holding 0x000101, 0x000202, 0x000303, 0x000404.

- `start` pulse, `cmd_ready`=1 → `xreset` low for exactly 10 cycles. First `cmd_valid` appears 7 cycles after `xreset` rises. Words arrive in ROM order, 3 cycles apart. `done`=1 after the 4th handshake.
- `cmd_ready` held low 20 cycles during the 2nd command → `cmd_valid`=1 with `cmd_data`=0x000202 stable throughout. No index advance.
- `reset` pulsed while the 3rd command is pending → all outputs at reset values on the same cycle, `xreset`=0. A new `start` replays from 0x000101.
- `start` pulsed during RST_WAIT → no effect; timing is identical to the first scenario.
- `start` in DONE → `xreset` falls again and the full 4-command sequence repeats.
- With `SPI_SEQ_GAP_EN` and `GAP_CYCLES`=8 → handshakes are 11 cycles apart. No gap follows the final command.
